// File: rtl/aes_package.sv
// Shared state encoding, default widths and address constants for the AES
// stream source and its response buffer.
package aes_package;

   localparam int unsigned AES_DATA_WIDTH_DEF = 32;
   localparam int unsigned AES_FIFO_DEPTH_DEF = 4;
   localparam int unsigned AES_SIZE_WIDTH_DEF = 16;
   localparam int unsigned AES_ADDR_WIDTH     = 32;

   localparam logic [31:0] AES_ADDR_STRIDE     = 32'd4;
   localparam logic [31:0] AES_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } aes_src_state_e;

   // Byte address of word idx of a transfer; wraps modulo 2^32 by construction.
   function automatic logic [31:0] aes_word_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
      return base + (idx * AES_ADDR_STRIDE);
   endfunction

endpackage

// File: rtl/aes_stream_fifo.sv
// Synchronous response buffer for aes_stream_source: power-of-two depth,
// simultaneous push/pop legal when full or empty, head visible without bypass.
module aes_stream_fifo
   import aes_package::*;
#(
   parameter int unsigned DATA_WIDTH = AES_DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = AES_FIFO_DEPTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  empty_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W:0]        count_r;
   logic                  do_pop_s;
   logic                  do_push_s;

   assign do_pop_s  = pop_i & (count_r != {(PTR_W + 1){1'b0}});
   assign do_push_s = push_i & ((count_r != DEPTH_C) | do_pop_s);
   assign empty_o   = (count_r == {(PTR_W + 1){1'b0}});
   assign head_o    = mem_r[rd_ptr_r];

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W + 1){1'b0}};
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (flush_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         count_r <= count_r + (PTR_W + 1)'(do_push_s) - (PTR_W + 1)'(do_pop_s);
      end
   end

endmodule

// File: rtl/aes_stream_source.sv
// Reads trans_size words from memory starting at base and streams them out
// over valid/ready, with credit-limited request issue into a small buffer.
// Optional: AES_STREAM_SOURCE_ALIGN_CHECK_EN rejects misaligned base addresses.
module aes_stream_source
   import aes_package::*;
#(
   parameter int unsigned DATA_WIDTH = AES_DATA_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = AES_FIFO_DEPTH_DEF,
   parameter int unsigned SIZE_WIDTH = AES_SIZE_WIDTH_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      req_start_i,
   output logic                      ready_start_o,
   input  logic [AES_ADDR_WIDTH-1:0] base_addr_i,
   input  logic [SIZE_WIDTH-1:0]     trans_size_i,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic [AES_ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                      mem_r_valid_i,
   input  logic [DATA_WIDTH-1:0]     mem_r_data_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_WIDTH-1:0]     data_o,
   output logic                      done_o
);

   localparam int unsigned CREDIT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CREDIT_W-1:0] CREDIT_DEPTH = CREDIT_W'(FIFO_DEPTH);

   aes_src_state_e            state_r, state_nxt_s;
   logic [31:0]               base_r, base_nxt_s;
   logic [SIZE_WIDTH-1:0]     size_r, size_nxt_s;
   logic [SIZE_WIDTH-1:0]     issued_r, issued_nxt_s;
   logic [SIZE_WIDTH-1:0]     popped_r, popped_nxt_s;
   // Words granted but not yet popped: outstanding reads plus buffer occupancy.
   logic [CREDIT_W-1:0]       in_flight_r, in_flight_nxt_s;
   logic                      mem_req_r, mem_req_nxt_s;
   logic [31:0]               mem_addr_r, mem_addr_nxt_s;
   logic                      start_done_r, start_done_nxt_s;
   logic                      discard_r;
   logic                      abort_s;
   logic                      grant_s;
   logic                      pop_s;
   logic                      push_s;
   logic                      last_pop_s;
   logic                      misalign_s;
   logic                      fifo_empty_s;
   logic [DATA_WIDTH-1:0]     fifo_head_s;

`ifdef AES_STREAM_SOURCE_ALIGN_CHECK_EN
   assign misalign_s = (base_addr_i[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   assign abort_s = rst_i | clear_i;
   assign grant_s = mem_req_r & mem_gnt_i;
   assign pop_s   = ~fifo_empty_s & ready_i;
   // A response in the cycle after an abort belongs to the aborted transfer.
   assign push_s  = mem_r_valid_i & ~discard_r;

   aes_stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (clear_i),
      .push_i      (push_s),
      .push_data_i (mem_r_data_i),
      .pop_i       (pop_s),
      .empty_o     (fifo_empty_s),
      .head_o      (fifo_head_s)
   );

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_nxt_s      = state_r;
      base_nxt_s       = base_r;
      size_nxt_s       = size_r;
      issued_nxt_s     = issued_r;
      popped_nxt_s     = popped_r;
      in_flight_nxt_s  = in_flight_r;
      start_done_nxt_s = 1'b0;
      last_pop_s       = 1'b0;

      if (abort_s) begin
         state_nxt_s     = ST_IDLE;
         issued_nxt_s    = {SIZE_WIDTH{1'b0}};
         popped_nxt_s    = {SIZE_WIDTH{1'b0}};
         in_flight_nxt_s = {CREDIT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_start_i) begin
                  base_nxt_s      = base_addr_i & AES_ADDR_ALIGN_MASK;
                  size_nxt_s      = trans_size_i;
                  issued_nxt_s    = {SIZE_WIDTH{1'b0}};
                  popped_nxt_s    = {SIZE_WIDTH{1'b0}};
                  in_flight_nxt_s = {CREDIT_W{1'b0}};
                  if (misalign_s || (trans_size_i == {SIZE_WIDTH{1'b0}})) begin
                     start_done_nxt_s = 1'b1;
                  end else begin
                     state_nxt_s = ST_ISSUE;
                  end
               end else begin
                  start_done_nxt_s = 1'b0;
               end
            end
            ST_ISSUE: begin
               issued_nxt_s    = issued_r + SIZE_WIDTH'(grant_s);
               popped_nxt_s    = popped_r + SIZE_WIDTH'(pop_s);
               in_flight_nxt_s = in_flight_r + CREDIT_W'(grant_s) - CREDIT_W'(pop_s);
               if (grant_s && (issued_nxt_s == size_r)) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end
            ST_DRAIN: begin
               popped_nxt_s    = popped_r + SIZE_WIDTH'(pop_s);
               in_flight_nxt_s = in_flight_r - CREDIT_W'(pop_s);
               if (pop_s && (popped_nxt_s == size_r)) begin
                  last_pop_s  = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end

      // Credits only shrink while a request waits, so an ungranted request stays up.
      mem_req_nxt_s = (state_nxt_s == ST_ISSUE) && (issued_nxt_s < size_nxt_s) &&
                      (in_flight_nxt_s < CREDIT_DEPTH);
      if (mem_req_nxt_s) begin
         mem_addr_nxt_s = aes_word_addr(base_nxt_s, 32'(issued_nxt_s));
      end else begin
         mem_addr_nxt_s = 32'h0000_0000;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         base_r       <= 32'h0000_0000;
         size_r       <= {SIZE_WIDTH{1'b0}};
         issued_r     <= {SIZE_WIDTH{1'b0}};
         popped_r     <= {SIZE_WIDTH{1'b0}};
         in_flight_r  <= {CREDIT_W{1'b0}};
         mem_req_r    <= 1'b0;
         mem_addr_r   <= 32'h0000_0000;
         start_done_r <= 1'b0;
         discard_r    <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         base_r       <= base_nxt_s;
         size_r       <= size_nxt_s;
         issued_r     <= issued_nxt_s;
         popped_r     <= popped_nxt_s;
         in_flight_r  <= in_flight_nxt_s;
         mem_req_r    <= mem_req_nxt_s;
         mem_addr_r   <= mem_addr_nxt_s;
         start_done_r <= start_done_nxt_s;
         discard_r    <= clear_i;
      end
   end

   assign ready_start_o = (state_r == ST_IDLE);
   assign mem_req_o     = mem_req_r;
   assign mem_addr_o    = mem_addr_r;
   assign valid_o       = ~fifo_empty_s;
   assign data_o        = fifo_head_s;
   assign done_o        = (start_done_r | last_pop_s) & ~abort_s;

endmodule

// File: tb/tb_aes_stream_source.sv
// Directed bench for aes_stream_source with a one-cycle-latency memory model.
module tb_aes_stream_source;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        clear_i = 1'b0;
   logic        req_start_i = 1'b0;
   logic        ready_start_o;
   logic [31:0] base_addr_i = 32'h0;
   logic [15:0] trans_size_i = 16'h0;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b1;
   logic [31:0] mem_addr_o;
   logic        mem_r_valid_i = 1'b0;
   logic [31:0] mem_r_data_i = 32'h0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] data_o;
   logic        done_o;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          dones = 0;
   int          done_cyc = 0;
   logic        gnt_pending = 1'b0;
   logic [31:0] gnt_addr = 32'h0;
   logic [31:0] gaddr_q[$];
   int          gcyc_q[$];
   logic [31:0] pop_q[$];
   int          pop_cyc_q[$];

   aes_stream_source dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .req_start_i   (req_start_i),
      .ready_start_o (ready_start_o),
      .base_addr_i   (base_addr_i),
      .trans_size_i  (trans_size_i),
      .mem_req_o     (mem_req_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_addr_o    (mem_addr_o),
      .mem_r_valid_i (mem_r_valid_i),
      .mem_r_data_i  (mem_r_data_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .data_o        (data_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Sample the current cycle, cross the clock edge, then drive the memory response.
   task automatic tick();
      #1;
      cyc++;
      if (mem_req_o && mem_gnt_i) begin
         gaddr_q.push_back(mem_addr_o);
         gcyc_q.push_back(cyc);
      end
      if (valid_o && ready_i) begin
         pop_q.push_back(data_o);
         pop_cyc_q.push_back(cyc);
      end
      if (done_o) begin
         dones++;
         done_cyc = cyc;
      end
      gnt_pending = mem_req_o & mem_gnt_i;
      gnt_addr    = mem_addr_o;
      @(posedge clk_i);
      #1;
      mem_r_valid_i = gnt_pending;
      mem_r_data_i  = gnt_pending ? mem_word(gnt_addr) : 32'h0;
   endtask

   task automatic clear_logs();
      gaddr_q.delete();
      gcyc_q.delete();
      pop_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] size);
      base_addr_i  = base;
      trans_size_i = size;
      req_start_i  = 1'b1;
      tick();
      req_start_i  = 1'b0;
   endtask

   task automatic run_done(input string name, input int budget);
      int d0;
      int n;
      d0 = dones;
      n  = 0;
      while (dones == d0 && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (dones == d0) begin
         bad++;
         $display("FAIL %s_timeout: done_o seen %0d times, required 1 within %0d cycles", name, 0, budget);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_start_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
      total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_a [4];
      int d0;
      exp_a = '{32'h1C01_0000, 32'h1C01_0004, 32'h1C01_0008, 32'h1C01_000C};
      clear_logs();
      mem_gnt_i = 1'b1;
      ready_i   = 1'b1;
      d0 = dones;
      start(32'h1C01_0000, 16'd4);
      run_done("basic", 40);
      tick();
      tick();
      total++; if (gaddr_q.size() != 4) begin bad++; $display("FAIL basic_grants: got %0d want 4", gaddr_q.size()); end
      for (int i = 0; i < 4 && i < gaddr_q.size(); i++) begin
         total++; if (gaddr_q[i] !== exp_a[i]) begin bad++; $display("FAIL basic_addr%0d: got %h want %h", i, gaddr_q[i], exp_a[i]); end
         total++; if (gcyc_q[i] != gcyc_q[0] + i) begin bad++; $display("FAIL basic_consec%0d: cycle %0d want %0d", i, gcyc_q[i], gcyc_q[0] + i); end
      end
      total++; if (pop_q.size() != 4) begin bad++; $display("FAIL basic_pops: got %0d want 4", pop_q.size()); end
      for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
         total++; if (pop_q[i] !== mem_word(exp_a[i])) begin bad++; $display("FAIL basic_data%0d: got %h want %h", i, pop_q[i], mem_word(exp_a[i])); end
      end
      if (pop_q.size() == 4 && gcyc_q.size() > 0) begin
         total++; if (pop_cyc_q[0] < gcyc_q[0] + 2) begin bad++; $display("FAIL basic_latency: first pop cycle %0d want >= %0d", pop_cyc_q[0], gcyc_q[0] + 2); end
         total++; if (done_cyc != pop_cyc_q[3]) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, pop_cyc_q[3]); end
      end
      total++; if (dones - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", dones - d0); end
      total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL basic_idle: got %b want 1", ready_start_o); end
   endtask

   task automatic test_gnt_stall();
      clear_logs();
      mem_gnt_i = 1'b0;
      start(32'h1C06_0000, 16'd2);
      for (int i = 0; i < 3; i++) begin
         total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL stall_req%0d: got %b want 1", i, mem_req_o); end
         total++; if (mem_addr_o !== 32'h1C06_0000) begin bad++; $display("FAIL stall_addr%0d: got %h want 1c060000", i, mem_addr_o); end
         tick();
      end
      mem_gnt_i = 1'b1;
      run_done("stall", 40);
      total++; if (gaddr_q.size() != 2) begin bad++; $display("FAIL stall_grants: got %0d want 2", gaddr_q.size()); end
      if (gaddr_q.size() == 2) begin
         total++; if (gaddr_q[1] !== 32'h1C06_0004) begin bad++; $display("FAIL stall_addr2: got %h want 1c060004", gaddr_q[1]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] base;
      int d0;
      base = 32'h1C02_0000;
      clear_logs();
      ready_i   = 1'b0;
      mem_gnt_i = 1'b1;
      d0 = dones;
      start(base, 16'd8);
      for (int i = 0; i < 20; i++) begin
         if (i == 6) begin
            base_addr_i  = 32'h0000_0000;
            trans_size_i = 16'd2;
            req_start_i  = 1'b1;
         end else begin
            req_start_i  = 1'b0;
         end
         tick();
      end
      total++; if (gaddr_q.size() != 4) begin bad++; $display("FAIL bp_grants_held: got %0d want 4", gaddr_q.size()); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL bp_req_held: got %b want 0", mem_req_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", valid_o); end
      ready_i = 1'b1;
      run_done("bp", 60);
      tick();
      total++; if (gaddr_q.size() != 8) begin bad++; $display("FAIL bp_grants: got %0d want 8", gaddr_q.size()); end
      total++; if (pop_q.size() != 8) begin bad++; $display("FAIL bp_pops: got %0d want 8", pop_q.size()); end
      for (int i = 0; i < 8 && i < gaddr_q.size(); i++) begin
         total++; if (gaddr_q[i] !== base + 32'(4 * i)) begin bad++; $display("FAIL bp_addr%0d: got %h want %h", i, gaddr_q[i], base + 32'(4 * i)); end
      end
      for (int i = 0; i < 8 && i < pop_q.size(); i++) begin
         total++; if (pop_q[i] !== mem_word(base + 32'(4 * i))) begin bad++; $display("FAIL bp_data%0d: got %h want %h", i, pop_q[i], mem_word(base + 32'(4 * i))); end
      end
      total++; if (dones - d0 != 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", dones - d0); end
   endtask

   task automatic test_zero_size();
      int d0;
      clear_logs();
      d0 = dones;
      start(32'h1C03_0000, 16'd0);
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done_o); end
      total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL zero_ready: got %b want 1", ready_start_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL zero_req: got %b want 0", mem_req_o); end
      for (int i = 0; i < 4; i++) tick();
      total++; if (dones - d0 != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", dones - d0); end
      total++; if (gaddr_q.size() != 0) begin bad++; $display("FAIL zero_grants: got %0d want 0", gaddr_q.size()); end
   endtask

   task automatic test_clear();
      int d0;
      clear_logs();
      ready_i   = 1'b0;
      mem_gnt_i = 1'b1;
      d0 = dones;
      start(32'h1C04_0000, 16'd8);
      tick();
      tick();
      total++; if (gaddr_q.size() != 2) begin bad++; $display("FAIL clr_pre_grants: got %0d want 2", gaddr_q.size()); end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      total++; if (ready_start_o !== 1'b1) begin bad++; $display("FAIL clr_idle: got %b want 1", ready_start_o); end
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", valid_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL clr_req: got %b want 0", mem_req_o); end
      tick();
      tick();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL clr_stray: got %b want 0", valid_o); end
      total++; if (dones != d0) begin bad++; $display("FAIL clr_no_done: got %0d want 0", dones - d0); end
      clear_logs();
      ready_i = 1'b1;
      start(32'h1C05_0000, 16'd2);
      run_done("clr_restart", 40);
      tick();
      tick();
      total++; if (pop_q.size() != 2) begin bad++; $display("FAIL clr_restart_pops: got %0d want 2", pop_q.size()); end
      if (pop_q.size() == 2) begin
         total++; if (pop_q[0] !== mem_word(32'h1C05_0000)) begin bad++; $display("FAIL clr_restart_d0: got %h want %h", pop_q[0], mem_word(32'h1C05_0000)); end
         total++; if (pop_q[1] !== mem_word(32'h1C05_0004)) begin bad++; $display("FAIL clr_restart_d1: got %h want %h", pop_q[1], mem_word(32'h1C05_0004)); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      clear_logs();
      start(32'hFFFF_FFF8, 16'd4);
      run_done("wrap", 40);
      total++; if (gaddr_q.size() != 4) begin bad++; $display("FAIL wrap_grants: got %0d want 4", gaddr_q.size()); end
      for (int i = 0; i < 4 && i < gaddr_q.size(); i++) begin
         total++; if (gaddr_q[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, gaddr_q[i], exp_a[i]); end
      end
      for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
         total++; if (pop_q[i] !== mem_word(exp_a[i])) begin bad++; $display("FAIL wrap_data%0d: got %h want %h", i, pop_q[i], mem_word(exp_a[i])); end
      end
   endtask

   task automatic test_align();
      int d0;
      clear_logs();
      d0 = dones;
      start(32'h1C01_0002, 16'd1);
`ifdef AES_STREAM_SOURCE_ALIGN_CHECK_EN
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL align_done: got %b want 1", done_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL align_req: got %b want 0", mem_req_o); end
      for (int i = 0; i < 4; i++) tick();
      total++; if (gaddr_q.size() != 0) begin bad++; $display("FAIL align_grants: got %0d want 0", gaddr_q.size()); end
      total++; if (dones - d0 != 1) begin bad++; $display("FAIL align_done_count: got %0d want 1", dones - d0); end
`else
      total++; if (mem_addr_o !== 32'h1C01_0000) begin bad++; $display("FAIL align_addr: got %h want 1c010000", mem_addr_o); end
      run_done("align", 40);
      total++; if (pop_q.size() != 1) begin bad++; $display("FAIL align_pops: got %0d want 1", pop_q.size()); end
      if (pop_q.size() == 1) begin
         total++; if (pop_q[0] !== mem_word(32'h1C01_0000)) begin bad++; $display("FAIL align_data: got %h want %h", pop_q[0], mem_word(32'h1C01_0000)); end
      end
      total++; if (dones - d0 != 1) begin bad++; $display("FAIL align_done_count: got %0d want 1", dones - d0); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gnt_stall();
      test_backpressure();
      test_zero_size();
      test_clear();
      test_wrap();
      test_align();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
